// File: rtl/mul_accumulator_pkg.sv
// Shared types and constants for the product accumulator.
// Width helpers and saturation limits live here.
package mul_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int acc_w(int nb, int guard);
    return 2 * nb + guard;
  endfunction

  // Largest signed value of a w-bit word, w <= 64.
  function automatic logic [63:0] sat_max(int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Smallest signed value of a w-bit word, w <= 64.
  function automatic logic [63:0] sat_min(int w);
    logic [63:0] r;
    r = '1;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mul_accumulator_if.sv
// Handshake bundle between multiplier side and consumer.
// master drives products/ack, slave is the accumulator.
interface mul_accumulator_if
  import mul_pkg::*;
#(
  parameter int nb        = 8,
  parameter int NUM_TERMS = 4,
  parameter int ACC_GUARD = 4
);

  localparam int PW   = 2 * nb;
  localparam int ACCW = acc_w(nb, ACC_GUARD);
  localparam int TCW  = $clog2(NUM_TERMS + 1);

  logic            clear;
  logic            mul_ready;
  logic [PW-1:0]   mul_product;
  logic [ACCW-1:0] acc_out;
  logic            acc_valid;
  logic            acc_ack;
  logic [TCW-1:0]  term_count;
  logic            busy;
  logic            overflow;
  logic            overrun;

  modport master (
    output clear,
    output mul_ready,
    output mul_product,
    output acc_ack,
    input  acc_out,
    input  acc_valid,
    input  term_count,
    input  busy,
    input  overflow,
    input  overrun
  );

  modport slave (
    input  clear,
    input  mul_ready,
    input  mul_product,
    input  acc_ack,
    output acc_out,
    output acc_valid,
    output term_count,
    output busy,
    output overflow,
    output overrun
  );

endinterface

// File: rtl/mul_accumulator_sat_add.sv
// Signed saturating adder, W bits in and out.
// ovf flags that the result was clamped.
module sat_add
  import mul_pkg::*;
#(
  parameter int W = 20
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic [W-1:0] MAXV = W'(sat_max(W));
  localparam logic [W-1:0] MINV = W'(sat_min(W));

  logic [W:0] full;

  // One extra bit exposes overflow; clamp by direction.
  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    ovf  = full[W] ^ full[W-1];
    sum  = full[W-1:0];
    if (ovf) sum = full[W] ? MINV : MAXV;
  end

endmodule

// File: rtl/mul_accumulator.sv
// Sums NUM_TERMS multiplier products with saturation and
// presents each sum on a valid/ack handshake.
module mul_accumulator
  import mul_pkg::*;
#(
  parameter int nb        = 8,
  parameter int NUM_TERMS = 4,
  parameter int ACC_GUARD = 4
) (
  input logic         clk,
  input logic         rst,
  mul_accumulator_if.slave bus
);

  localparam int PW   = 2 * nb;
  localparam int ACCW = acc_w(nb, ACC_GUARD);
  localparam int TCW  = $clog2(NUM_TERMS + 1);

  localparam logic [TCW-1:0] TC_FULL = TCW'(NUM_TERMS);
  localparam logic [TCW-1:0] TC_ONE  = TCW'(1);
  localparam logic [TCW-1:0] TC_TWO  = TCW'(2);

  localparam logic [0:0] ST_ACCUM = ACCUM;
  localparam logic [0:0] ST_HOLD  = HOLD;

  logic [0:0]      state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] out_q, out_d;
  logic            valid_q, valid_d;
  logic [TCW-1:0]  tc_q, tc_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            pend_v_q, pend_v_d;
  logic            ovf_q, ovf_d;
  logic            ovr_q, ovr_d;
  logic            prev_q;

  logic                   cap;
  logic signed [PW-1:0]   prod_s;
  logic signed [PW-1:0]   pend_s;
  logic signed [ACCW-1:0] p_ext;
  logic signed [ACCW-1:0] pend_ext;
  logic signed [ACCW-1:0] add_a;
  logic signed [ACCW-1:0] add_sum;
  logic                   add_ovf;
  logic [TCW-1:0]         tc_inc;

  assign cap      = bus.mul_ready & ~prev_q;
  assign prod_s   = bus.mul_product;
  assign pend_s   = pend_q;
  assign p_ext    = ACCW'(prod_s);
  assign pend_ext = ACCW'(pend_s);
  assign tc_inc   = tc_q + TC_ONE;

  // Pending product is the left operand only on a drained ack.
  assign add_a = (state_q == ST_HOLD && pend_v_q)
               ? pend_ext : acc_q;

  sat_add #(.W(ACCW)) u_add (
    .a   (add_a),
    .b   (p_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Next-state: accumulate, hold result, absorb one early term.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    out_d    = out_q;
    valid_d  = valid_q;
    tc_d     = tc_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ovf_d    = ovf_q;
    ovr_d    = ovr_q;
    if (bus.clear) begin
      state_d  = ST_ACCUM;
      acc_d    = '0;
      out_d    = '0;
      valid_d  = 1'b0;
      tc_d     = '0;
      pend_d   = '0;
      pend_v_d = 1'b0;
      ovf_d    = 1'b0;
      ovr_d    = 1'b0;
    end else if (state_q == ST_ACCUM) begin
      if (cap) begin
        acc_d = add_sum;
        ovf_d = ovf_q | add_ovf;
        tc_d  = tc_inc;
        if (tc_inc == TC_FULL) begin
          out_d   = add_sum;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
    end else if (bus.acc_ack) begin
      valid_d = 1'b0;
      acc_d   = '0;
      state_d = ST_ACCUM;
      if (!pend_v_q) begin
        if (cap) begin
          acc_d = p_ext;
          tc_d  = TC_ONE;
        end else begin
          tc_d  = '0;
        end
      end else if (!cap) begin
        acc_d    = pend_ext;
        tc_d     = TC_ONE;
        pend_v_d = 1'b0;
      end else begin
        acc_d    = add_sum;
        ovf_d    = ovf_q | add_ovf;
        tc_d     = TC_TWO;
        pend_v_d = 1'b0;
        if (TC_TWO == TC_FULL) begin
          out_d   = add_sum;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
    end else if (cap) begin
      if (!pend_v_q) begin
        pend_d   = bus.mul_product;
        pend_v_d = 1'b1;
      end else begin
        ovr_d    = 1'b1;
      end
    end
  end

  // Edge detector history; a high ready at release never captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= bus.mul_ready;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACCUM;
      acc_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      tc_q     <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      tc_q     <= tc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.acc_out    = out_q;
  assign bus.acc_valid  = valid_q;
  assign bus.term_count = tc_q;
  assign bus.busy       = (tc_q != '0) | valid_q;
  assign bus.overflow   = ovf_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: two instances,
// 4 guard bits and 0 guard bits.
module tb_mul_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul_accumulator_if #(.nb(8), .NUM_TERMS(4), .ACC_GUARD(4)) ifa ();
  mul_accumulator_if #(.nb(8), .NUM_TERMS(4), .ACC_GUARD(0)) ifb ();

  mul_accumulator #(.nb(8), .NUM_TERMS(4), .ACC_GUARD(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  mul_accumulator #(.nb(8), .NUM_TERMS(4), .ACC_GUARD(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a(input logic [15:0] p);
    @(negedge clk);
    ifa.mul_ready   = 1'b1;
    ifa.mul_product = p;
    @(negedge clk);
    ifa.mul_ready   = 1'b0;
  endtask

  task automatic pulse_b(input logic [15:0] p);
    @(negedge clk);
    ifb.mul_ready   = 1'b1;
    ifb.mul_product = p;
    @(negedge clk);
    ifb.mul_ready   = 1'b0;
  endtask

  task automatic ack_a();
    @(negedge clk);
    ifa.acc_ack = 1'b1;
    @(negedge clk);
    ifa.acc_ack = 1'b0;
  endtask

  task automatic clear_a();
    @(negedge clk);
    ifa.clear = 1'b1;
    @(negedge clk);
    ifa.clear = 1'b0;
  endtask

  initial begin
    ifa.clear = 0; ifa.mul_ready = 0; ifa.mul_product = '0; ifa.acc_ack = 0;
    ifb.clear = 0; ifb.mul_ready = 0; ifb.mul_product = '0; ifb.acc_ack = 0;
    #1;
    chk("rst_tc",    64'(ifa.term_count), 64'd0);
    chk("rst_valid", 64'(ifa.acc_valid),  64'd0);
    chk("rst_busy",  64'(ifa.busy),       64'd0);
    chk("rst_out",   64'(ifa.acc_out),    64'd0);
    chk("rst_ovf",   64'(ifa.overflow),   64'd0);
    chk("rst_ovr",   64'(ifa.overrun),    64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 3, -5, 100, 7 -> 105
    pulse_a(16'd3);
    pulse_a(-16'sd5);
    pulse_a(16'd100);
    chk("dot_tc3",    64'(ifa.term_count), 64'd3);
    chk("dot_nvalid", 64'(ifa.acc_valid),  64'd0);
    chk("dot_acc3",   64'(dut_a.acc_q),    64'd98);
    pulse_a(16'd7);
    chk("dot_valid",  64'(ifa.acc_valid),  64'd1);
    chk("dot_out",    64'(ifa.acc_out),    64'd105);
    chk("dot_tc4",    64'(ifa.term_count), 64'd4);
    chk("dot_ovf",    64'(ifa.overflow),   64'd0);
    chk("dot_busy",   64'(ifa.busy),       64'd1);
    ack_a();
    chk("ack_valid",  64'(ifa.acc_valid),  64'd0);
    chk("ack_tc",     64'(ifa.term_count), 64'd0);
    chk("ack_busy",   64'(ifa.busy),       64'd0);

    // ready held high 5 cycles counts once
    @(negedge clk);
    ifa.mul_ready   = 1'b1;
    ifa.mul_product = 16'd9;
    repeat (5) @(negedge clk);
    ifa.mul_ready   = 1'b0;
    chk("hold_tc1",   64'(ifa.term_count), 64'd1);
    pulse_a(16'd9);
    chk("hold_tc2",   64'(ifa.term_count), 64'd2);
    chk("hold_acc",   64'(dut_a.acc_q),    64'd18);

    // clear wins over a coincident capture of 50
    @(negedge clk);
    ifa.clear       = 1'b1;
    ifa.mul_ready   = 1'b1;
    ifa.mul_product = 16'd50;
    @(negedge clk);
    ifa.clear       = 1'b0;
    ifa.mul_ready   = 1'b0;
    chk("clr_tc",     64'(ifa.term_count), 64'd0);
    chk("clr_acc",    64'(dut_a.acc_q),    64'd0);
    chk("clr_busy",   64'(ifa.busy),       64'd0);

    // held result, one pending, one dropped
    pulse_a(16'd1);
    pulse_a(16'd2);
    pulse_a(16'd3);
    pulse_a(16'd4);
    chk("pend_out",   64'(ifa.acc_out),    64'd10);
    pulse_a(16'd11);
    chk("pend_ovr0",  64'(ifa.overrun),    64'd0);
    chk("pend_valid", 64'(ifa.acc_valid),  64'd1);
    pulse_a(16'd12);
    chk("pend_ovr1",  64'(ifa.overrun),    64'd1);
    chk("pend_keep",  64'(ifa.acc_out),    64'd10);
    ack_a();
    chk("pend_nval",  64'(ifa.acc_valid),  64'd0);
    chk("pend_tc",    64'(ifa.term_count), 64'd1);
    chk("pend_acc",   64'(dut_a.acc_q),    64'd11);
    chk("pend_ovrS",  64'(ifa.overrun),    64'd1);
    clear_a();
    chk("pend_ovrC",  64'(ifa.overrun),    64'd0);

    // ack with pending full and a capture in the same cycle
    pulse_a(16'd1);
    pulse_a(16'd1);
    pulse_a(16'd1);
    pulse_a(16'd1);
    chk("pc_out",     64'(ifa.acc_out),    64'd4);
    pulse_a(16'd5);
    @(negedge clk);
    ifa.acc_ack     = 1'b1;
    ifa.mul_ready   = 1'b1;
    ifa.mul_product = 16'd6;
    @(negedge clk);
    ifa.acc_ack     = 1'b0;
    ifa.mul_ready   = 1'b0;
    chk("pc_valid",   64'(ifa.acc_valid),  64'd0);
    chk("pc_tc",      64'(ifa.term_count), 64'd2);
    chk("pc_acc",     64'(dut_a.acc_q),    64'd11);
    clear_a();

    // async reset mid-sum with ready high
    pulse_a(16'd4);
    pulse_a(16'd6);
    chk("ar_tc2",     64'(ifa.term_count), 64'd2);
    @(negedge clk);
    ifa.mul_ready   = 1'b1;
    ifa.mul_product = 16'd7;
    #2 rst = 1'b1;
    #1;
    chk("ar_tc",      64'(ifa.term_count), 64'd0);
    chk("ar_busy",    64'(ifa.busy),       64'd0);
    chk("ar_acc",     64'(dut_a.acc_q),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("ar_nocap",   64'(ifa.term_count), 64'd0);
    ifa.mul_ready = 1'b0;
    pulse_a(16'd7);
    chk("ar_cap",     64'(ifa.term_count), 64'd1);
    chk("ar_acc7",    64'(dut_a.acc_q),    64'd7);

    // saturation with zero guard bits
    pulse_b(16'd16384);
    pulse_b(16'd16384);
    chk("sat_ovf2",   64'(ifb.overflow),   64'd1);
    pulse_b(16'd16384);
    pulse_b(16'd16384);
    chk("sat_valid",  64'(ifb.acc_valid),  64'd1);
    chk("sat_out",    64'(ifb.acc_out),    64'h7fff);
    chk("sat_ovf",    64'(ifb.overflow),   64'd1);
    @(negedge clk);
    ifb.acc_ack = 1'b1;
    @(negedge clk);
    ifb.acc_ack = 1'b0;
    chk("sat_nval",   64'(ifb.acc_valid),  64'd0);
    chk("sat_ovfS",   64'(ifb.overflow),   64'd1);
    @(negedge clk);
    ifb.clear = 1'b1;
    @(negedge clk);
    ifb.clear = 1'b0;
    chk("sat_ovfC",   64'(ifb.overflow),   64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
